reg_file_sequencer: RTL

Transaction-level controller in front of the dual-read register file. It accepts one decoded instruction at a time over a valid/ready handshake and drives the register file's opcode, address and write-enable inputs through issue, wait and write-back phases. It starts the ALU or RAM access and returns a response carrying read data or an error flag. It sits between the instruction decoder and the register file, ALU and data RAM, and is the only master of the register file control inputs.

---
 rtl/reg_file_sequencer_pkg.sv | 25 ++
 rtl/reg_file_sequencer_classify.sv | 20 ++
 rtl/reg_file_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_sequencer_pkg.sv
// Shared types for the register file sequencer and decoder:
// opcode constants, FSM state enum and instruction-class enum.
package reg_file_sequencer_pkg;

    localparam logic [3:0]  OP_ALU_NIB   = 4'b0001;
    localparam logic [7:0]  OP_READ      = 8'h22;
    localparam logic [7:0]  OP_WRITE_RAM = 8'h42;
    localparam logic [15:0] OP_NOP       = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_RESP
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_READ,
        CLS_RAM,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/reg_file_sequencer_classify.sv
// Opcode classifier (module reg_file_op_classify), shared with the decoder.
// Ports: i_opcode (16-bit opcode word) -> o_class (instruction class).
module reg_file_op_classify
    import reg_file_sequencer_pkg::*;
(
    input  logic [15:0]  i_opcode,
    output instr_class_t o_class
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        unique case (1'b1)
            (i_opcode[15:12] == OP_ALU_NIB):  o_class = CLS_ALU;
            (i_opcode[15:8] == OP_READ):      o_class = CLS_READ;
            (i_opcode[15:8] == OP_WRITE_RAM): o_class = CLS_RAM;
            default:                          o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/reg_file_sequencer.sv
// Transaction sequencer in front of the dual-read register file.
// Ports: instr_* handshake in, rf_* register file control out,
// alu_*/ram_* execution side, resp_* response handshake out.
// Optional watchdog in WAIT: define SEQ_WATCHDOG_EN.
module reg_file_sequencer
    import reg_file_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [15:0]           instr_opcode,
    input  logic [3:0]            instr_a1,
    input  logic [3:0]            instr_a2,
    input  logic [3:0]            instr_a3,
    output logic [15:0]           rf_opcode,
    output logic [3:0]            rf_addr_1,
    output logic [3:0]            rf_addr_2,
    output logic [3:0]            rf_addr_3,
    output logic                  rf_write_enable,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_read_data_reg,
    output logic                  alu_start,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  ram_req,
    input  logic                  ram_ack,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err
);

    instr_class_t          w_class;
    instr_class_t          r_class;
    seq_state_t            r_state;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_wait_data;

    reg_file_op_classify u_classify (
        .i_opcode (instr_opcode),
        .o_class  (w_class)
    );

    // Only the completion of the class in flight counts.
    assign w_hit = (r_class == CLS_ALU) ? alu_done :
                   (r_class == CLS_RAM) ? ram_ack  : 1'b0;
    assign w_wait_data = (r_class == CLS_ALU) ? alu_result
                                              : ram_rdata;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_LOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W   = (WD_LOG > 8) ? WD_LOG : 8;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_wd_expire;

    // Counter holds the number of WAIT cycles already spent,
    // so expiry falls on the TIMEOUT_CYCLES-th WAIT cycle.
    assign w_wd_expire = (r_wd_cnt == WD_LAST);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_class         <= CLS_ILLEGAL;
            instr_ready     <= 1'b1;
            rf_opcode       <= OP_NOP;
            rf_addr_1       <= 4'h0;
            rf_addr_2       <= 4'h0;
            rf_addr_3       <= 4'h0;
            rf_write_enable <= 1'b0;
            rf_write_data   <= '0;
            alu_start       <= 1'b0;
            ram_req         <= 1'b0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_err        <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            r_wd_cnt        <= '0;
`endif
        end else begin
            alu_start       <= 1'b0;
            rf_write_enable <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_class     <= w_class;
                        r_state     <= ST_ISSUE;
                        instr_ready <= 1'b0;
                        alu_start   <= (w_class == CLS_ALU);
                        ram_req     <= (w_class == CLS_RAM);
                        // Illegal ops keep the NOP on the register
                        // file so it sees no access at all.
                        if (w_class != CLS_ILLEGAL) begin
                            rf_opcode <= instr_opcode;
                            rf_addr_1 <= instr_a1;
                            rf_addr_2 <= instr_a2;
                            rf_addr_3 <= instr_a3;
                        end
                    end
                end
                ST_ISSUE: begin
                    unique case (r_class)
                        CLS_ALU, CLS_RAM: begin
                            r_state  <= ST_WAIT;
`ifdef SEQ_WATCHDOG_EN
                            r_wd_cnt <= '0;
`endif
                        end
                        CLS_READ: begin
                            resp_data  <= rf_read_data_reg;
                            resp_err   <= 1'b0;
                            resp_valid <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                        default: begin
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (w_hit) begin
                        ram_req         <= 1'b0;
                        rf_write_enable <= 1'b1;
                        rf_write_data   <= w_wait_data;
                        resp_data       <= w_wait_data;
                        resp_err        <= 1'b0;
                        r_state         <= ST_WB;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (w_wd_expire) begin
                        ram_req    <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                ST_WB: begin
                    resp_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid  <= 1'b0;
                        instr_ready <= 1'b1;
                        rf_opcode   <= OP_NOP;
                        rf_addr_1   <= 4'h0;
                        rf_addr_2   <= 4'h0;
                        rf_addr_3   <= 4'h0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
